// File: rtl/condicionador_pkg.sv
// condicionador_pkg: shared definitions for the button conditioning stage
//   estado_t    : button FSM state encoding (also driven onto db_estado)
//   NUM_BOTOES  : number of raw push-buttons
//   isola_menor : keeps only the lowest-index set bit of a button vector
package condicionador_pkg;
   localparam int NUM_BOTOES = 4;
   typedef enum logic [1:0] {
      OCIOSO       = 2'd0,
      ESPERA_PRESS = 2'd1,
      PRESSIONADO  = 2'd2,
      ESPERA_SOLTA = 2'd3
   } estado_t;
   // v & -v leaves exactly the least significant set bit
   function automatic logic [NUM_BOTOES-1:0] isola_menor(input logic [NUM_BOTOES-1:0] v);
      return v & (~v + 1'b1);
   endfunction
endpackage

// File: rtl/debounce_estavel.sv
// debounce_estavel: 2-flop synchroniser plus saturating stability counter
//   clock, reset : system clock, asynchronous active-high reset
//   d_in         : raw asynchronous input vector
//   s            : synchronised vector
//   estavel      : s has held the same value for DEBOUNCE_CYCLES cycles
module debounce_estavel
   import condicionador_pkg::*;
#(
   parameter int LARGURA         = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] d_in,
   output logic [LARGURA-1:0] s,
   output logic               estavel
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [LARGURA-1:0] sync_q, s_q, s_ant_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   always_comb begin
      cnt_d = (s_q != s_ant_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         s_q     <= '0;
         s_ant_q <= '0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= d_in;
         s_q     <= sync_q;
         s_ant_q <= s_q;
         cnt_q   <= cnt_d;
      end
   end
   assign s = s_q;
   // a saturated count left over from the previous value must not validate a
   // vector that has only just changed
   assign estavel = (cnt_q == CNT_MAX) && (s_q == s_ant_q);
endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronise, debounce and one-press-one-move the game inputs
//   clock, reset  : system clock, asynchronous active-high reset
//   botoes[3:0]   : raw push-buttons;  jogar : raw start key
//   jogada[3:0]   : registered one-hot accepted move
//   jogada_pulso  : one cycle when jogada is loaded
//   tem_jogada    : high from acceptance until the release is debounced
//   jogar_pulso   : one cycle on each debounced rising edge of jogar
//   db_estado     : FSM state for the hex display
// Build option REJEITA_MULTIPLO_EN: reject stable vectors with more than one
// bit set instead of picking the lowest-index button.
module condicionador_botoes
   import condicionador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_BOTOES-1:0] botoes,
   input  logic                  jogar,
   output logic [NUM_BOTOES-1:0] jogada,
   output logic                  jogada_pulso,
   output logic                  tem_jogada,
   output logic                  jogar_pulso,
   output logic [1:0]            db_estado
);
   logic [NUM_BOTOES-1:0] s_bot;
   logic                  est_bot, s_jog, est_jog, aceita;
   estado_t               estado_q, estado_d;
   logic [NUM_BOTOES-1:0] jogada_q, jogada_d;
   logic                  jogada_pulso_q, jogada_pulso_d;
   logic                  tem_jogada_q, tem_jogada_d;
   logic                  jogar_db_q, jogar_db_d;
   logic                  jogar_pulso_q, jogar_pulso_d;
   debounce_estavel #(.LARGURA(NUM_BOTOES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_botoes (
      .clock   (clock),
      .reset   (reset),
      .d_in    (botoes),
      .s       (s_bot),
      .estavel (est_bot)
   );
   debounce_estavel #(.LARGURA(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jogar (
      .clock   (clock),
      .reset   (reset),
      .d_in    (jogar),
      .s       (s_jog),
      .estavel (est_jog)
   );
`ifdef REJEITA_MULTIPLO_EN
   assign aceita = $onehot(s_bot);
`else
   assign aceita = 1'b1;
`endif
   always_comb begin
      estado_d       = estado_q;
      jogada_d       = jogada_q;
      jogada_pulso_d = 1'b0;
      tem_jogada_d   = tem_jogada_q;
      case (estado_q)
         OCIOSO:       if (s_bot != '0) estado_d = ESPERA_PRESS;
         ESPERA_PRESS: begin
            if (s_bot == '0) estado_d = OCIOSO;
            else if (est_bot) begin
               estado_d = PRESSIONADO;
               if (aceita) begin
                  jogada_d       = isola_menor(s_bot);
                  jogada_pulso_d = 1'b1;
                  tem_jogada_d   = 1'b1;
               end
            end
         end
         PRESSIONADO:  if (s_bot == '0) estado_d = ESPERA_SOLTA;
         ESPERA_SOLTA: begin
            if (s_bot != '0) estado_d = PRESSIONADO;
            else if (est_bot) begin
               estado_d     = OCIOSO;
               tem_jogada_d = 1'b0;
            end
         end
      endcase
      jogar_db_d    = est_jog ? s_jog : jogar_db_q;
      jogar_pulso_d = est_jog & s_jog & ~jogar_db_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q       <= OCIOSO;
         jogada_q       <= '0;
         jogada_pulso_q <= 1'b0;
         tem_jogada_q   <= 1'b0;
         jogar_db_q     <= 1'b0;
         jogar_pulso_q  <= 1'b0;
      end else begin
         estado_q       <= estado_d;
         jogada_q       <= jogada_d;
         jogada_pulso_q <= jogada_pulso_d;
         tem_jogada_q   <= tem_jogada_d;
         jogar_db_q     <= jogar_db_d;
         jogar_pulso_q  <= jogar_pulso_d;
      end
   end
   assign jogada       = jogada_q;
   assign jogada_pulso = jogada_pulso_q;
   assign tem_jogada   = tem_jogada_q;
   assign jogar_pulso  = jogar_pulso_q;
   assign db_estado    = estado_q;
endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes: directed vector table plus reset and bounce sequences
module tb_condicionador_botoes;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] botoes = 4'b0000;
   logic       jogar = 1'b0;
   logic [3:0] jogada;
   logic       jogada_pulso, tem_jogada, jogar_pulso;
   logic [1:0] db_estado;
   int n_cmp = 0;
   int n_err = 0;
   int cnt_pj, cnt_pg;
   always #5 clock = ~clock;
   condicionador_botoes #(.DEBOUNCE_CYCLES(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .jogar        (jogar),
      .jogada       (jogada),
      .jogada_pulso (jogada_pulso),
      .tem_jogada   (tem_jogada),
      .jogar_pulso  (jogar_pulso),
      .db_estado    (db_estado)
   );
   typedef struct {
      logic [3:0] b;
      logic       j;
      int         n;
      logic [3:0] e_jogada;
      logic       e_pulso;
      logic       e_tem;
      logic       e_jp;
      logic [1:0] e_est;
      int         e_pj;
      int         e_pg;
   } vec_t;
   vec_t tab[$];
   task automatic tick();
      @(posedge clock);
      #1;
      if (jogada_pulso) cnt_pj++;
      if (jogar_pulso) cnt_pg++;
   endtask
   task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nome, got, exp);
      end
   endtask
   function automatic logic [8:0] saidas();
      return {jogada, jogada_pulso, tem_jogada, jogar_pulso, db_estado};
   endfunction
   initial begin
      logic [3:0] multi_jogada;
      logic       multi_tem;
      int         multi_pj;
      int         at;
`ifdef REJEITA_MULTIPLO_EN
      multi_jogada = 4'b0001; multi_tem = 1'b0; multi_pj = 0;
`else
      multi_jogada = 4'b0010; multi_tem = 1'b1; multi_pj = 1;
`endif
      // clean press of 0100 and its release
      tab.push_back('{4'b0100, 1'b0,  2, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      tab.push_back('{4'b0100, 1'b0,  1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 0, 0});
      tab.push_back('{4'b0100, 1'b0,  3, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 0, 0});
      tab.push_back('{4'b0100, 1'b0,  1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 1, 0});
      tab.push_back('{4'b0100, 1'b0,  1, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 0, 0});
      tab.push_back('{4'b0100, 1'b0, 12, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 0, 0});
      tab.push_back('{4'b0000, 1'b0,  3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0});
      tab.push_back('{4'b0000, 1'b0,  3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0});
      tab.push_back('{4'b0000, 1'b0,  1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      tab.push_back('{4'b0000, 1'b0,  5, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      // hold 1000, switch to 0001 without release, then release and re-press
      tab.push_back('{4'b1000, 1'b0,  7, 4'b1000, 1'b1, 1'b1, 1'b0, 2'd2, 1, 0});
      tab.push_back('{4'b1000, 1'b0,  5, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd2, 0, 0});
      tab.push_back('{4'b0001, 1'b0, 10, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd2, 0, 0});
      tab.push_back('{4'b0000, 1'b0,  7, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      tab.push_back('{4'b0001, 1'b0,  7, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd2, 1, 0});
      tab.push_back('{4'b0000, 1'b0, 10, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      // multi-button press
      tab.push_back('{4'b0110, 1'b0, 10, multi_jogada, 1'b0, multi_tem, 1'b0, 2'd2, multi_pj, 0});
      tab.push_back('{4'b0000, 1'b0, 10, multi_jogada, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      // jogar and a button rising together
      tab.push_back('{4'b0100, 1'b1,  6, multi_jogada, 1'b0, 1'b0, 1'b0, 2'd1, 0, 0});
      tab.push_back('{4'b0100, 1'b1,  1, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 1, 1});
      tab.push_back('{4'b0000, 1'b0, 10, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0});
      // power-on reset
      repeat (3) tick();
      check("reset_outputs", 32'(saidas()), 32'd0);
      reset = 1'b0;
      repeat (10) tick();
      check("idle_outputs", 32'(saidas()), 32'd0);
      foreach (tab[i]) begin
         botoes = tab[i].b;
         jogar  = tab[i].j;
         cnt_pj = 0;
         cnt_pg = 0;
         repeat (tab[i].n) tick();
         check($sformatf("vec%0d_outputs", i), 32'(saidas()),
               32'({tab[i].e_jogada, tab[i].e_pulso, tab[i].e_tem, tab[i].e_jp, tab[i].e_est}));
         check($sformatf("vec%0d_jogada_pulsos", i), 32'(cnt_pj), 32'(tab[i].e_pj));
         check($sformatf("vec%0d_jogar_pulsos", i), 32'(cnt_pg), 32'(tab[i].e_pg));
      end
      // bounce on botoes[0]: 2-cycle segments never reach stability
      cnt_pj = 0;
      for (int k = 0; k < 4; k++) begin
         botoes = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         repeat (2) tick();
      end
      check("bounce_no_pulse", 32'(cnt_pj), 32'd0);
      botoes = 4'b0001;
      cnt_pj = 0;
      at = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (jogada_pulso && at == 0) at = t;
      end
      check("bounce_pulse_count", 32'(cnt_pj), 32'd1);
      check("bounce_pulse_edge", 32'(at), 32'd7);
      check("bounce_jogada", 32'(jogada), 32'b0001);
      // asynchronous reset mid-operation with 0010 held
      botoes = 4'b0010;
      repeat (3) tick();
      check("pre_reset_state", 32'(db_estado), 32'd2);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", 32'(saidas()), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      cnt_pj = 0;
      at = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (jogada_pulso && at == 0) at = t;
      end
      check("post_reset_pulse_count", 32'(cnt_pj), 32'd1);
      check("post_reset_pulse_edge", 32'(at), 32'd7);
      check("post_reset_jogada", 32'(jogada), 32'b0010);
      botoes = 4'b0000;
      repeat (10) tick();
      check("final_idle", 32'({tem_jogada, db_estado}), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input conditioning stage placed directly upstream of the memory game top level. It synchronises the four raw push-buttons and the `jogar` key to `clock`, debounces them, and enforces one-press-one-move. It delivers a one-hot registered move, a single-cycle `jogada_pulso`, a `tem_jogada` level and a single-cycle `jogar_pulso`, which the game data path and control unit consume in place of raw pins.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles required before accepting a press or release. Minimum 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clock`  in  1  system clock, all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `botoes`  in  4  raw buttons, active-high, asynchronous to `clock`.
- `jogar`  in  1  raw start key, active-high, asynchronous.
- `jogada`  out  4  registered one-hot accepted move; holds the last value until the next acceptance; 0 after reset.
- `jogada_pulso`  out  1  high for exactly one cycle when `jogada` updates; 0 after reset.
- `tem_jogada`  out  1  high from acceptance until release is debounced; 0 after reset.
- `jogar_pulso`  out  1  one-cycle pulse on a debounced rising edge of `jogar`; 0 after reset.
- `db_estado`  out  2  current FSM state encoding, for the hex display; 0 (`OCIOSO`) after reset.

## Operation
- Both `botoes` and `jogar` pass through 2-flop synchronisers. Downstream logic sees only the synchronised vector `s`.
- Stability counter:
  - Cleared on any cycle where `s` differs from its previous-cycle value.
  - Otherwise increments, saturating at `DEBOUNCE_CYCLES-1`.
  - `estavel` is asserted when the counter equals `DEBOUNCE_CYCLES-1`.
- FSM states:
  - `OCIOSO` (0): `s != 0` → `ESPERA_PRESS`.
  - `ESPERA_PRESS` (1):
    - `s == 0` → `OCIOSO`.
    - `estavel` with an acceptable vector → load `jogada`, pulse `jogada_pulso`, set `tem_jogada`, go to `PRESSIONADO`.
    - `estavel` with a non-acceptable vector → `PRESSIONADO` without loading or pulsing.
  - `PRESSIONADO` (2): `s == 0` → `ESPERA_SOLTA`.
  - `ESPERA_SOLTA` (3):
    - `s != 0` → `PRESSIONADO`.
    - `estavel` with `s == 0` → clear `tem_jogada`, go to `OCIOSO`.
- A press while in `PRESSIONADO` or `ESPERA_SOLTA` is never accepted. A new move requires a full debounced release first.
- `jogar` has its own instance of the same counter logic. `jogar_pulso` fires once per debounced 0→1 transition and is independent of the button FSM.
- On `reset` mid-operation: every register clears immediately, and a button held through reset release counts as a new press once it is stable.

## Timing
- Latency: a new stable value first sampled at edge k produces `jogada_pulso`/`jogada` registered at edge k+2+`DEBOUNCE_CYCLES`.
- `tem_jogada` rises on the same edge as `jogada_pulso`.
- `tem_jogada` falls 2+`DEBOUNCE_CYCLES` edges after the release is first sampled.
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count. A bounce during `ESPERA_PRESS` that returns to 0 aborts to `OCIOSO` with no pulse.
- `jogada_pulso` and `jogar_pulso` may both be high in the same cycle. Both are reported and neither has priority.
- The counter saturates and never wraps.

## Configuration
- `REJEITA_MULTIPLO_EN` defined: a stable vector with more than one bit set is non-acceptable. No move is produced, and the FSM waits in `PRESSIONADO` for a full release.
- `REJEITA_MULTIPLO_EN` undefined: a multi-bit vector is accepted, and `jogada` is the lowest-index set bit (priority 0 > 1 > 2 > 3), always one-hot.

## Structure
- Shared package `condicionador_pkg`:
  - state enum `OCIOSO=2'd0`, `ESPERA_PRESS=2'd1`, `PRESSIONADO=2'd2`, `ESPERA_SOLTA=2'd3`;
  - `NUM_BOTOES=4`.
- One natural sub-module, `debounce_estavel`: synchroniser plus stability counter, parameterised by width and `DEBOUNCE_CYCLES`, with outputs `s` and `estavel`. It is instantiated twice, once for width 4 (buttons) and once for width 1 (`jogar`).
- The FSM and output registers live in the top level.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset: assert `reset` asynchronously with `botoes=4'b0010` held → all outputs 0 and `db_estado=0`. After release and 6 stable cycles → `jogada=4'b0010` with one `jogada_pulso`.
- Clean press: `botoes=4'b0100` held 20 cycles then 0 →
  - `jogada_pulso` high for exactly 1 cycle, 6 edges after the change;
  - `jogada=4'b0100`;
  - `tem_jogada` falls 6 edges after release.
- Bounce: toggle `botoes[0]` every 2 cycles for 10 cycles, then hold 1 → exactly one pulse, 6 edges after the final toggle.
- Hold and re-press: hold `4'b1000`, then switch to `4'b0001` without releasing → no second pulse. A `4'b0001` move is accepted only after a full debounced release.
- Multi-press with `4'b0110` held:
  - `REJEITA_MULTIPLO_EN` defined → no pulse and `jogada` unchanged;
  - undefined → `jogada=4'b0010`.
- `jogar` and a button rising on the same edge → `jogar_pulso` and `jogada_pulso` are both high on the same cycle.
